mjpg_stream_sequencer: RTL
==========================

Name: mjpg_stream_sequencer

Overview:
Frame-level controller for the MJPG encoder output path. It replays the JPEG header from an external byte ROM and patches in the frame height and width. It then grants the shared output byte bus to the Y/Cb/Cr entropy encoders block by block, in MCU order, and closes each frame with EOI. It sits between the per-component entropy/byte-stuffing stages and the jvalid/jpeg output.

Parameters:
NCOMP, 3, number of requesting component encoders (0=Y, 1=Cb, 2=Cr)
BLK_PER_MCU, 4, blocks per MCU (4:2:2 = Y,Y,Cb,Cr)
BLK_SEQ, 8'b10_01_00_00, 2-bit component ID per block slot, slot 0 in LSBs
HDR_LEN, 623, header bytes replayed from ROM (SOI through end of SOS)
HGT_OFS, 143, ROM offset of height MSB; height LSB, width MSB and width LSB follow at +1..+3
MCU_W, 16, counter width for MCUs per frame

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active low
frame_start  in  1  one-cycle pulse at vsync; starts a frame
cfg_width  in  16  frame width in pixels; latched on frame_start
cfg_height  in  16  frame height in pixels; latched on frame_start
cfg_mcus  in  MCU_W  MCUs per frame; latched on frame_start; 0 is illegal
hdr_addr  out  10  header ROM address
hdr_data  in  8  header ROM byte; valid one cycle after hdr_addr
ereq  in  NCOMP  component has an encoded block ready
egrant  out  NCOMP  one-hot bus grant
evalid  in  NCOMP  byte valid from the granted component
edata  in  8*NCOMP  byte lanes, component c at [8c+:8]
edone  in  NCOMP  qualifies the last byte of the current block
elast  out  1  current granted block is the last block of the frame; requester flushes its bit buffer with 1-padding
jvalid  out  1  output byte strobe
jpeg  out  8  output byte
busy  out  1  high in any state except IDLE
err_overlap  out  1  one-cycle pulse when frame_start arrives while busy

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0.
- Clocking: one clock; rst_n is asynchronous and active low and clears everything immediately, including mid-frame. No partial EOI is emitted on reset.
- States: IDLE, HDR, WAIT, XFER, EOI0, EOI1.
- IDLE:
  - On frame_start, latch cfg_*, set hdr_addr=0 and go to HDR.
- HDR:
  - hdr_addr increments by 1 per cycle from 0 to HDR_LEN-1.
  - jvalid=1 with jpeg equal to the byte for address k, registered, one cycle after hdr_addr=k.
  - Patch substitution: HGT_OFS gives height[15:8], +1 gives height[7:0], +2 gives width[15:8], +3 gives width[7:0].
  - Header output therefore lasts exactly HDR_LEN cycles, starting one cycle after entry.
  - After the last header byte, go to WAIT with slot=0 and mcu=0.
- WAIT:
  - comp = BLK_SEQ[2*slot+:2].
  - Stay until ereq[comp]=1, then assert egrant[comp] (one-hot) in the next cycle and go to XFER.
  - ereq from any other component is ignored; that requester holds its request.
- XFER:
  - Each cycle with evalid[comp]=1 drives jvalid=1 and jpeg=edata lane comp, registered (1-cycle latency).
  - evalid from non-granted lanes is ignored.
  - On evalid&edone for comp, drop egrant in the next cycle.
  - Advance: slot+1; when slot wraps at BLK_PER_MCU-1, mcu+1.
  - If mcu reaches cfg_mcus-1 and slot BLK_PER_MCU-1 has completed, go to EOI0; otherwise go to WAIT.
  - elast=1 while the granted block is slot BLK_PER_MCU-1 of MCU cfg_mcus-1.
- EOI0: emit 0xFF. EOI1: emit 0xD9, then go to IDLE. These are consecutive jvalid cycles.
- frame_start while busy: ignored, err_overlap pulses, and the current frame continues unchanged.
- frame_start in the same cycle as the EOI1 exit is treated as busy and ignored.
- jvalid never asserts in IDLE or WAIT. At most one byte per cycle.

Optional Feature:
MJPG_SEQ_RST_MARKER_EN.
- Enabled:
  - New parameter RST_INTERVAL (default 4) and new output dc_reset (1 bit).
  - After every RST_INTERVAL completed MCUs, except after the final MCU, emit 0xFF then 0xD0+(n mod 8), where n counts markers from 0 per frame.
  - Pulse dc_reset for one cycle so requesters zero their DC predictors and byte-align.
  - Two extra states, RST0 and RST1, sit between XFER and WAIT.
  - The header ROM must contain a DRI segment.
- Disabled: no marker states, dc_reset absent, behaviour exactly as above.

Decomposition:
- Shared package mjpg_pkg:
  - component ID constants
  - marker bytes: SOI 8'hD8, EOI 8'hD9, RST base 8'hD0, prefix 8'hFF
  - state enumeration
  - BLK_SEQ encoding for 4:2:2
- One sub-module, mjpg_hdr_replay: address counter, ROM-latency alignment and patch mux, reporting a done pulse to the sequencer.

Test Plan:
- Header replay: cfg 640x360, cfg_mcus=1, ROM byte = address low bits. Bytes 143..146 output as 0x01,0x68,0x02,0x80; all others match ROM; HDR_LEN jvalid cycles.
- Block order: all ereq held high, each block 3 bytes, cfg_mcus=2. Grant sequence Y,Y,Cb,Cr,Y,Y,Cb,Cr; output is the 24 lane bytes in order, then 0xFF,0xD9; busy then drops.
- Starvation: Cb ready before the second Y. egrant stays on Y and waits; no Cb byte appears before the second Y block's edone.
- Gapped evalid: Y evalid toggles 1/0 for 5 bytes. Exactly 5 jvalid pulses; elast=1 only during the final block of the frame.
- Overlap: frame_start mid-XFER. err_overlap pulses once; the byte stream is identical to the run without the extra pulse.
- Async reset mid-HDR (rst_n low at byte 50). All outputs 0 in the same cycle; the next frame_start replays from address 0. With the macro enabled and RST_INTERVAL=1, cfg_mcus=3: 0xFFD0 and 0xFFD1 are inserted, and dc_reset pulses twice.

Source files
------------

// File: rtl/mjpg_pkg.sv
// Shared constants and types for the MJPG frame sequencer and header replay.
package mjpg_pkg;

  localparam logic [1:0] COMP_Y  = 2'd0;
  localparam logic [1:0] COMP_CB = 2'd1;
  localparam logic [1:0] COMP_CR = 2'd2;

  localparam logic [7:0] MK_PFX = 8'hFF;
  localparam logic [7:0] MK_SOI = 8'hD8;
  localparam logic [7:0] MK_EOI = 8'hD9;
  localparam logic [7:0] MK_RST = 8'hD0;

  // 4:2:2 slot map, slot 0 in the LSBs: Y, Y, Cb, Cr
  localparam logic [7:0] BLK_SEQ_422 = {COMP_CR, COMP_CB, COMP_Y, COMP_Y};

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_WAIT, S_XFER, S_EOI0, S_EOI1, S_RST0, S_RST1
  } seq_state_e;

  typedef struct packed {
    logic [15:0] height;
    logic [15:0] width;
  } frame_dim_t;

endpackage

// File: rtl/mjpg_stream_sequencer_if.sv
// Entropy-encoder byte bus shared between the component encoders and the sequencer.
interface mjpg_stream_sequencer_if #(
  parameter int NCOMP = 3
);
  logic [NCOMP-1:0]   ereq;
  logic [NCOMP-1:0]   egrant;
  logic [NCOMP-1:0]   evalid;
  logic [NCOMP-1:0]   edone;
  logic [8*NCOMP-1:0] edata;
  logic               elast;

  modport master (input ereq, evalid, edone, edata, output egrant, elast);
  modport slave  (output ereq, evalid, edone, edata, input egrant, elast);
endinterface

// File: rtl/mjpg_hdr_replay.sv
// Header ROM replay: address counter, one-cycle ROM latency alignment and
// height/width patch mux. done_o marks the cycle the final header byte is out.
module mjpg_hdr_replay
  import mjpg_pkg::*;
#(
  parameter int HDR_LEN = 623,
  parameter int HGT_OFS = 143,
  parameter int AW      = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  frame_dim_t    dim_i,
  output logic [AW-1:0] addr_o,
  input  logic [7:0]    data_i,
  output logic          vld_o,
  output logic [7:0]    byte_o,
  output logic          done_o
);
  localparam int STAGES = 1;

  logic [STAGES:0] vld_pipe;
  logic [AW-1:0]   addr_q, addr_d, oaddr_q;
  logic            last, act_d;
  logic [7:0]      pbyte;

  assign last   = vld_pipe[0] && (addr_q == AW'(HDR_LEN-1));
  assign act_d  = start_i || (vld_pipe[0] && !last);
  assign addr_o = addr_q;

  always_comb begin
    addr_d = addr_q;
    if (vld_pipe[0]) addr_d = last ? '0 : addr_q + AW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      addr_q   <= '0;
      oaddr_q  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], act_d};
      addr_q   <= addr_d;
      oaddr_q  <= addr_q;
    end
  end

  // ROM data arrives one cycle after its address; oaddr_q tracks which byte it is
  always_comb begin
    pbyte = data_i;
    if      (oaddr_q == AW'(HGT_OFS))   pbyte = dim_i.height[15:8];
    else if (oaddr_q == AW'(HGT_OFS+1)) pbyte = dim_i.height[7:0];
    else if (oaddr_q == AW'(HGT_OFS+2)) pbyte = dim_i.width[15:8];
    else if (oaddr_q == AW'(HGT_OFS+3)) pbyte = dim_i.width[7:0];
  end

  assign vld_o  = vld_pipe[STAGES];
  assign byte_o = vld_pipe[STAGES] ? pbyte : 8'h00;
  assign done_o = vld_pipe[STAGES] && (oaddr_q == AW'(HDR_LEN-1));

endmodule

// File: rtl/mjpg_stream_sequencer.sv
// MJPG output frame sequencer: header replay, MCU-ordered block grants, EOI.
// Define MJPG_SEQ_RST_MARKER_EN to insert RSTn markers every RST_INTERVAL MCUs.
module mjpg_stream_sequencer
  import mjpg_pkg::*;
#(
  parameter int                       NCOMP       = 3,
  parameter int                       BLK_PER_MCU = 4,
  parameter logic [2*BLK_PER_MCU-1:0] BLK_SEQ     = BLK_SEQ_422,
  parameter int                       HDR_LEN     = 623,
  parameter int                       HGT_OFS     = 143,
  parameter int                       MCU_W       = 16
`ifdef MJPG_SEQ_RST_MARKER_EN
  , parameter int                     RST_INTERVAL = 4
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_start_i,
  input  logic [15:0]            cfg_width_i,
  input  logic [15:0]            cfg_height_i,
  input  logic [MCU_W-1:0]       cfg_mcus_i,
  output logic [9:0]             hdr_addr_o,
  input  logic [7:0]             hdr_data_i,
  mjpg_stream_sequencer_if.master eb,
  output logic                   jvalid_o,
  output logic [7:0]             jpeg_o,
  output logic                   busy_o,
  output logic                   err_overlap_o
`ifdef MJPG_SEQ_RST_MARKER_EN
  , output logic                 dc_reset_o
`endif
);
  localparam int SW = (BLK_PER_MCU > 1) ? $clog2(BLK_PER_MCU) : 1;

  seq_state_e             state_q, state_d;
  logic [SW-1:0]          slot_q, slot_d;
  logic [MCU_W-1:0]       mcu_q, mcu_d, mcus_q;
  logic [NCOMP-1:0]       grant_q, grant_d;
  logic                   xv_q, xv_d, err_q;
  logic [7:0]             xb_q, xb_d;
  frame_dim_t             dim_q;
  logic [1:0]             comp;
  logic                   slot_last, mcu_last, hdr_start;
  logic                   hdr_vld, hdr_done, mk_vld;
  logic [7:0]             hdr_byte, mk_byte;
  logic [NCOMP-1:0][7:0]  lane;
`ifdef MJPG_SEQ_RST_MARKER_EN
  logic [MCU_W-1:0]       rcnt_q, rcnt_d;
  logic [2:0]             rnum_q, rnum_d;
`endif

  for (genvar c = 0; c < NCOMP; c++) begin : g_lane
    assign lane[c] = eb.edata[8*c +: 8];
  end

  assign comp      = 2'(BLK_SEQ >> {slot_q, 1'b0});
  assign slot_last = (slot_q == SW'(BLK_PER_MCU-1));
  assign mcu_last  = (mcu_q == mcus_q - MCU_W'(1));
  assign hdr_start = (state_q == S_IDLE) && frame_start_i;

  mjpg_hdr_replay #(.HDR_LEN(HDR_LEN), .HGT_OFS(HGT_OFS), .AW(10)) u_hdr (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (hdr_start),
    .dim_i   (dim_q),
    .addr_o  (hdr_addr_o),
    .data_i  (hdr_data_i),
    .vld_o   (hdr_vld),
    .byte_o  (hdr_byte),
    .done_o  (hdr_done)
  );

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    mcu_d   = mcu_q;
    grant_d = grant_q;
    xv_d    = 1'b0;
    xb_d    = 8'h00;
`ifdef MJPG_SEQ_RST_MARKER_EN
    rcnt_d  = rcnt_q;
    rnum_d  = rnum_q;
`endif
    case (state_q)
      S_IDLE: if (frame_start_i) state_d = S_HDR;
      S_HDR: if (hdr_done) begin
        state_d = S_WAIT;
        slot_d  = '0;
        mcu_d   = '0;
`ifdef MJPG_SEQ_RST_MARKER_EN
        rcnt_d  = '0;
        rnum_d  = '0;
`endif
      end
      S_WAIT: if (eb.ereq[comp]) begin
        grant_d = NCOMP'(1) << comp;
        state_d = S_XFER;
      end
      S_XFER: begin
        if (grant_q != '0) begin
          if (eb.evalid[comp]) begin
            xv_d = 1'b1;
            xb_d = lane[comp];
            if (eb.edone[comp]) grant_d = '0;
          end
        end else begin
          // Drain cycle: the block's last byte is on jpeg_o, now pick the next slot
          state_d = S_WAIT;
          if (!slot_last) begin
            slot_d = slot_q + SW'(1);
          end else begin
            slot_d = '0;
            if (mcu_last) begin
              state_d = S_EOI0;
            end else begin
              mcu_d = mcu_q + MCU_W'(1);
`ifdef MJPG_SEQ_RST_MARKER_EN
              if (rcnt_q == MCU_W'(RST_INTERVAL-1)) begin
                rcnt_d  = '0;
                state_d = S_RST0;
              end else begin
                rcnt_d  = rcnt_q + MCU_W'(1);
              end
`endif
            end
          end
        end
      end
      S_EOI0: state_d = S_EOI1;
      S_EOI1: state_d = S_IDLE;
`ifdef MJPG_SEQ_RST_MARKER_EN
      S_RST0: state_d = S_RST1;
      S_RST1: begin
        state_d = S_WAIT;
        rnum_d  = rnum_q + 3'd1;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      slot_q  <= '0;
      mcu_q   <= '0;
      mcus_q  <= '0;
      grant_q <= '0;
      xv_q    <= 1'b0;
      xb_q    <= 8'h00;
      err_q   <= 1'b0;
      dim_q   <= '0;
`ifdef MJPG_SEQ_RST_MARKER_EN
      rcnt_q  <= '0;
      rnum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      mcu_q   <= mcu_d;
      grant_q <= grant_d;
      xv_q    <= xv_d;
      xb_q    <= xb_d;
      err_q   <= frame_start_i && (state_q != S_IDLE);
      if (hdr_start) begin
        dim_q  <= {cfg_height_i, cfg_width_i};
        mcus_q <= cfg_mcus_i;
      end
`ifdef MJPG_SEQ_RST_MARKER_EN
      rcnt_q  <= rcnt_d;
      rnum_q  <= rnum_d;
`endif
    end
  end

  // Marker bytes are decoded straight from state so EOI1 is the final busy cycle
  always_comb begin
    mk_vld  = 1'b0;
    mk_byte = MK_PFX;
    case (state_q)
      S_EOI0: mk_vld = 1'b1;
      S_EOI1: begin
        mk_vld  = 1'b1;
        mk_byte = MK_EOI;
      end
`ifdef MJPG_SEQ_RST_MARKER_EN
      S_RST0: mk_vld = 1'b1;
      S_RST1: begin
        mk_vld  = 1'b1;
        mk_byte = MK_RST | {5'd0, rnum_q};
      end
`endif
      default: ;
    endcase
  end

  assign jvalid_o      = hdr_vld || xv_q || mk_vld;
  assign jpeg_o        = hdr_vld ? hdr_byte : (xv_q ? xb_q : (mk_vld ? mk_byte : 8'h00));
  assign busy_o        = (state_q != S_IDLE);
  assign err_overlap_o = err_q;
  assign eb.egrant     = grant_q;
  assign eb.elast      = (state_q == S_XFER) && (grant_q != '0) && slot_last && mcu_last;
`ifdef MJPG_SEQ_RST_MARKER_EN
  assign dc_reset_o    = (state_q == S_RST1);
`endif

endmodule
